ibus_wait_responder: RTL and testbench

Synthesizable responder for the naive_mips instruction bus. It serves `ibus_read` requests from a synchronous-read instruction memory (boot ROM/BRAM), inserts a parameterised number of wait cycles, and drives `ibus_stall` and `ibus_rddata` back to the core. It sits between `naive_mips` ibus ports and an on-chip memory macro, and replaces the behavioural wait-state model used in simulation.

---
 rtl/ibus_wait_responder.sv | 118 +++++++++++
 tb/tb_ibus_wait_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_wait_responder.sv
// Instruction-bus responder: serves naive_mips ibus reads from a synchronous-read memory with WAIT_CYCLES extra stall cycles.
// Optional protocol checker enabled by defining IBUS_ABORT_CHECK_EN (drives the sticky abort_err flag).
module ibus_wait_responder #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ibus_address,
  input  logic                  ibus_read,
  input  logic                  ibus_write,
  input  logic [3:0]            ibus_byteenable,
  input  logic [31:0]           ibus_wrdata,
  output logic [31:0]           ibus_rddata,
  output logic                  ibus_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [31:0]           mem_rdata,
  output logic                  abort_err
);

  localparam int CNT_RAW = $clog2(WAIT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           data_reg;
  logic [31:0]           rddata_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ADDR_WIDTH-1:0] live_addr;

  assign live_addr   = ibus_address[ADDR_WIDTH+1:2];
  assign mem_addr    = (state_reg == IDLE) ? live_addr : addr_reg;
  assign ibus_stall  = ibus_read && (state_reg != DONE) && rst_n;
  assign ibus_rddata = rddata_reg;

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ibus_read) begin
          mem_en     = rst_n;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!ibus_read)     state_next = IDLE;
        else if (ZERO_WAIT) state_next = DONE;
        else                state_next = WAIT;
      end
      WAIT: begin
        if (!ibus_read)               state_next = IDLE;
        else if (cnt_reg == CNT_LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The output word is only published on entry to DONE, so an aborted fetch leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      data_reg   <= '0;
      rddata_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (ibus_read) addr_reg <= live_addr;
        end
        FETCH: begin
          if (ibus_read) begin
            data_reg <= mem_rdata;
            cnt_reg  <= '0;
            if (ZERO_WAIT) rddata_reg <= mem_rdata;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (state_next == DONE) rddata_reg <= data_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef IBUS_ABORT_CHECK_EN
  logic abort_reg;
  logic in_flight;

  assign in_flight = (state_reg == FETCH) || (state_reg == WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abort_reg <= 1'b0;
    end else if (ibus_write || (in_flight && (!ibus_read || (live_addr != addr_reg)))) begin
      abort_reg <= 1'b1;
    end
  end

  assign abort_err = abort_reg;
`else
  assign abort_err = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{ibus_byteenable, ibus_wrdata, ibus_write,
                           ibus_address[31:ADDR_WIDTH+2], ibus_address[1:0]};

endmodule

// File: tb/tb_ibus_wait_responder.sv
// Directed bench for ibus_wait_responder: one DUT with WAIT_CYCLES=4, one with WAIT_CYCLES=0, sharing a word memory model.
module tb_ibus_wait_responder;

`ifdef IBUS_ABORT_CHECK_EN
  localparam logic EXP_ABORT = 1'b1;
`else
  localparam logic EXP_ABORT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [0:2047];

  // DUT with four wait states
  logic [31:0] addr4 = '0;
  logic        read4 = 1'b0, write4 = 1'b0;
  logic [31:0] rddata4, mem_rdata4;
  logic        stall4, mem_en4, abort_err4;
  logic [10:0] mem_addr4;

  // DUT with zero wait states
  logic [31:0] addr0 = '0;
  logic        read0 = 1'b0;
  logic [31:0] rddata0, mem_rdata0;
  logic        stall0, mem_en0, abort_err0;
  logic [10:0] mem_addr0;

  always #5 clk = ~clk;

  ibus_wait_responder #(.ADDR_WIDTH(11), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ibus_address(addr4), .ibus_read(read4), .ibus_write(write4),
    .ibus_byteenable(4'hF), .ibus_wrdata(32'h0), .ibus_rddata(rddata4), .ibus_stall(stall4),
    .mem_addr(mem_addr4), .mem_en(mem_en4), .mem_rdata(mem_rdata4), .abort_err(abort_err4)
  );

  ibus_wait_responder #(.ADDR_WIDTH(11), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ibus_address(addr0), .ibus_read(read0), .ibus_write(1'b0),
    .ibus_byteenable(4'hF), .ibus_wrdata(32'h0), .ibus_rddata(rddata0), .ibus_stall(stall0),
    .mem_addr(mem_addr0), .mem_en(mem_en0), .mem_rdata(mem_rdata0), .abort_err(abort_err0)
  );

  always @(posedge clk) begin
    if (mem_en4) mem_rdata4 <= mem[mem_addr4];
    if (mem_en0) mem_rdata0 <= mem[mem_addr0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read4 = 1'b1;
    addr4 = 32'h40;
    tick();
    tick();
    sample();
    tests++;
    if (stall4 !== 1'b0 || mem_en4 !== 1'b0 || rddata4 !== 32'h0 || abort_err4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut4: stall=%b mem_en=%b rddata=%h abort=%b, expected 0 0 00000000 0",
               stall4, mem_en4, rddata4, abort_err4);
    end
    tests++;
    if (stall0 !== 1'b0 || mem_en0 !== 1'b0 || rddata0 !== 32'h0 || abort_err0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut0: stall=%b mem_en=%b rddata=%h abort=%b, expected 0 0 00000000 0",
               stall0, mem_en0, rddata0, abort_err0);
    end
    tick();
    rst_n = 1'b1;
    read4 = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_single_fetch();
    tick();
    read4 = 1'b1;
    addr4 = 32'h40;
    sample();
    tests++;
    if (stall4 !== 1'b1 || mem_en4 !== 1'b1 || mem_addr4 !== 11'h010) begin
      fails++;
      $display("FAIL single_c0: stall=%b mem_en=%b mem_addr=%h, expected 1 1 010", stall4, mem_en4, mem_addr4);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      sample();
      tests++;
      if (stall4 !== 1'b1 || mem_en4 !== 1'b0) begin
        fails++;
        $display("FAIL single_c%0d: stall=%b mem_en=%b, expected 1 0", c, stall4, mem_en4);
      end
    end
    tick();
    sample();
    tests++;
    if (stall4 !== 1'b0 || rddata4 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_done: stall=%b rddata=%h, expected 0 deadbeef", stall4, rddata4);
    end
    tick();
    read4 = 1'b0;
    sample();
    tests++;
    if (stall4 !== 1'b0 || mem_en4 !== 1'b0 || rddata4 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_hold: stall=%b mem_en=%b rddata=%h, expected 0 0 deadbeef", stall4, mem_en4, rddata4);
    end
    $display("[TB] single fetch 0x40 -> %h", rddata4);
  endtask

  task automatic test_abort();
    tick();
    read4 = 1'b1;
    addr4 = 32'h8;
    tick();
    tick();
    tick();
    read4 = 1'b0;
    sample();
    tests++;
    if (stall4 !== 1'b0) begin
      fails++;
      $display("FAIL abort_drop_stall: stall=%b, expected 0", stall4);
    end
    tick();
    addr4 = 32'h30;
    sample();
    tests++;
    if (mem_addr4 !== 11'h00C || stall4 !== 1'b0 || mem_en4 !== 1'b0 || rddata4 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL abort_idle: mem_addr=%h stall=%b mem_en=%b rddata=%h, expected 00c 0 0 deadbeef",
               mem_addr4, stall4, mem_en4, rddata4);
    end
    repeat (4) tick();
    sample();
    tests++;
    if (rddata4 !== 32'hDEADBEEF || abort_err4 !== EXP_ABORT) begin
      fails++;
      $display("FAIL abort_later: rddata=%h abort=%b, expected deadbeef %b", rddata4, abort_err4, EXP_ABORT);
    end
    $display("[TB] abort at 0x8 abort_err=%b", abort_err4);
  endtask

  task automatic test_zero_wait();
    tick();
    read0 = 1'b1;
    addr0 = 32'h0;
    sample();
    tests++;
    if (stall0 !== 1'b1 || mem_en0 !== 1'b1 || mem_addr0 !== 11'h000) begin
      fails++;
      $display("FAIL zw_a_c0: stall=%b mem_en=%b mem_addr=%h, expected 1 1 000", stall0, mem_en0, mem_addr0);
    end
    tick();
    sample();
    tests++;
    if (stall0 !== 1'b1) begin
      fails++;
      $display("FAIL zw_a_c1: stall=%b, expected 1", stall0);
    end
    tick();
    sample();
    tests++;
    if (stall0 !== 1'b0 || rddata0 !== mem[0]) begin
      fails++;
      $display("FAIL zw_a_done: stall=%b rddata=%h, expected 0 %h", stall0, rddata0, mem[0]);
    end
    tick();
    addr0 = 32'h4;
    sample();
    tests++;
    if (stall0 !== 1'b1 || mem_en0 !== 1'b1 || mem_addr0 !== 11'h001) begin
      fails++;
      $display("FAIL zw_b_c0: stall=%b mem_en=%b mem_addr=%h, expected 1 1 001", stall0, mem_en0, mem_addr0);
    end
    tick();
    sample();
    tests++;
    if (stall0 !== 1'b1) begin
      fails++;
      $display("FAIL zw_b_c1: stall=%b, expected 1", stall0);
    end
    tick();
    sample();
    tests++;
    if (stall0 !== 1'b0 || rddata0 !== mem[1]) begin
      fails++;
      $display("FAIL zw_b_done: stall=%b rddata=%h, expected 0 %h", stall0, rddata0, mem[1]);
    end
    tick();
    read0 = 1'b0;
    sample();
    tests++;
    if (rddata0 !== mem[1]) begin
      fails++;
      $display("FAIL zw_hold: rddata=%h, expected %h", rddata0, mem[1]);
    end
    $display("[TB] zero-wait fetches 0x0 0x4 -> %h", rddata0);
  endtask

  task automatic test_addr_change();
    int n;
    do_reset();
    sample();
    tests++;
    if (abort_err4 !== 1'b0 || rddata4 !== 32'h0) begin
      fails++;
      $display("FAIL addr_reset: abort=%b rddata=%h, expected 0 00000000", abort_err4, rddata4);
    end
    tick();
    read4 = 1'b1;
    addr4 = 32'h8;
    tick();
    tick();
    addr4 = 32'hC;
    sample();
    tests++;
    if (mem_addr4 !== 11'h002 || stall4 !== 1'b1) begin
      fails++;
      $display("FAIL addr_wait: mem_addr=%h stall=%b, expected 002 1", mem_addr4, stall4);
    end
    n = 2;
    while (stall4 === 1'b1 && n < 20) begin
      tick();
      sample();
      n++;
    end
    tests++;
    if (n !== 6 || rddata4 !== mem[2] || abort_err4 !== EXP_ABORT) begin
      fails++;
      $display("FAIL addr_done: cycle=%0d rddata=%h abort=%b, expected 6 %h %b", n, rddata4, abort_err4, mem[2], EXP_ABORT);
    end
    tick();
    read4 = 1'b0;
    $display("[TB] address change 0x8->0xC -> %h", rddata4);
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    tick();
    read4 = 1'b1;
    addr4 = 32'h40;
    tick();
    tick();
    rst_n = 1'b0;
    sample();
    tests++;
    if (stall4 !== 1'b0 || mem_en4 !== 1'b0) begin
      fails++;
      $display("FAIL rmf_in_reset: stall=%b mem_en=%b, expected 0 0", stall4, mem_en4);
    end
    tick();
    rst_n = 1'b1;
    addr4 = 32'h0;
    sample();
    tests++;
    if (rddata4 !== 32'h0 || stall4 !== 1'b1 || mem_en4 !== 1'b1 || mem_addr4 !== 11'h000 || abort_err4 !== 1'b0) begin
      fails++;
      $display("FAIL rmf_idle: rddata=%h stall=%b mem_en=%b mem_addr=%h abort=%b, expected 00000000 1 1 000 0",
               rddata4, stall4, mem_en4, mem_addr4, abort_err4);
    end
    n = 0;
    while (stall4 === 1'b1 && n < 20) begin
      tick();
      sample();
      n++;
    end
    tests++;
    if (n !== 6 || rddata4 !== mem[0]) begin
      fails++;
      $display("FAIL rmf_refetch: cycle=%0d rddata=%h, expected 6 %h", n, rddata4, mem[0]);
    end
    tick();
    read4 = 1'b0;
    $display("[TB] reset mid-fetch, refetch 0x0 -> %h", rddata4);
  endtask

  task automatic test_write();
    do_reset();
    tick();
    write4 = 1'b1;
    addr4 = 32'h20;
    sample();
    tests++;
    if (stall4 !== 1'b0 || mem_en4 !== 1'b0) begin
      fails++;
      $display("FAIL write_cycle: stall=%b mem_en=%b, expected 0 0", stall4, mem_en4);
    end
    tick();
    write4 = 1'b0;
    tick();
    tick();
    sample();
    tests++;
    if (abort_err4 !== EXP_ABORT || stall4 !== 1'b0) begin
      fails++;
      $display("FAIL write_abort: abort=%b stall=%b, expected %b 0", abort_err4, stall4, EXP_ABORT);
    end
    $display("[TB] write at 0x20 abort_err=%b", abort_err4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[16] = 32'hDEADBEEF;
    test_reset();
    test_single_fetch();
    test_abort();
    test_zero_wait();
    test_addr_change();
    test_reset_mid_fetch();
    test_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
